// File: rtl/lut_ni_arbiter.sv
// lut_ni_arbiter: round-robin arbiter that shares one combinational NI weight
// ROM among N_REQ lanes. One lookup accepted per cycle; the ROM address is
// registered (S1) and the returned word is captured one cycle later (S2) and
// presented with a one-hot lane strobe.
module lut_ni_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
    output logic [N_REQ-1:0]          o_req_ready,
    output logic [ADDR_W-1:0]         o_lut_addr,
    input  logic [DATA_W-1:0]         i_lut_dout,
    output logic [N_REQ-1:0]          o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0]     rr_ptr;
    logic [N_REQ-1:0]  grant;
    logic [PW-1:0]     grant_idx;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [N_REQ-1:0]  s1_tag;

    // Round-robin search starting one past the last granted lane, wrapping
    // explicitly at N_REQ-1 so non-power-of-two lane counts stay in range.
    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = rr_ptr;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (idx == PW'(N_REQ - 1)) ? '0 : idx + 1'b1;
            if (!found && i_req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    // Grant is suppressed during reset so nothing is accepted then.
    always_comb begin
        o_req_ready = i_rst ? '0 : grant;
        accept      = |(o_req_ready & i_req_valid);
    end

    // Select the granted lane's address for the ROM address register.
    always_comb begin
        sel_addr = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                sel_addr = i_req_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // Priority pointer: remember the last granted lane.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr <= PW'(N_REQ - 1);
        end else if (accept) begin
            rr_ptr <= grant_idx;
        end
    end

    // S1: register ROM address and lane tag; address holds when idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_lut_addr <= '0;
            s1_tag     <= '0;
        end else begin
            s1_tag <= accept ? o_req_ready : '0;
            if (accept) begin
                o_lut_addr <= sel_addr;
            end
        end
    end

    // S2: capture ROM word and emit the one-cycle response strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
        end else begin
            o_rsp_valid <= s1_tag;
            if (|s1_tag) begin
                o_rsp_data <= i_lut_dout;
            end
        end
    end

endmodule

// File: tb/tb_lut_ni_arbiter.sv
// Directed self-checking bench for lut_ni_arbiter with a behavioural ROM
// returning 24'hA00000 | addr.
module tb_lut_ni_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_ready;
    logic [7:0]  lut_addr;
    logic [23:0] lut_dout;
    logic [3:0]  rsp_valid;
    logic [23:0] rsp_data;

    int n_cmp;
    int n_fail;

    lut_ni_arbiter #(
        .N_REQ (4),
        .ADDR_W(8),
        .DATA_W(24)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_valid(req_valid),
        .i_req_addr (req_addr),
        .o_req_ready(req_ready),
        .o_lut_addr (lut_addr),
        .i_lut_dout (lut_dout),
        .o_rsp_valid(rsp_valid),
        .o_rsp_data (rsp_data)
    );

    // ROM model
    assign lut_dout = 24'hA00000 | {16'h0000, lut_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance to 1ns after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        req_addr = 32'h13121110;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_ready cyc%0d got %b want 0000", c, req_ready);
            end
            n_cmp++;
            if (rsp_valid !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_rsp_valid cyc%0d got %b want 0000", c, rsp_valid);
            end
            n_cmp++;
            if (lut_addr !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_lut_addr cyc%0d got %h want 00", c, lut_addr);
            end
            n_cmp++;
            if (rsp_data !== 24'h000000) begin
                n_fail++;
                $display("FAIL reset_rsp_data cyc%0d got %h want 000000", c, rsp_data);
            end
        end
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        // cycle 0
        req_valid = 4'b0100;
        req_addr = 32'h005C0000;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ready got %b want 0100", req_ready);
        end
        next_cycle();
        // cycle 1
        req_valid = '0;
        n_cmp++;
        if (lut_addr !== 8'h5C) begin
            n_fail++;
            $display("FAIL single_lut_addr got %h want 5c", lut_addr);
        end
        n_cmp++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_early_rsp got %b want 0000", rsp_valid);
        end
        next_cycle();
        // cycle 2
        n_cmp++;
        if (rsp_valid !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_rsp_valid got %b want 0100", rsp_valid);
        end
        n_cmp++;
        if (rsp_data !== 24'hA0005C) begin
            n_fail++;
            $display("FAIL single_rsp_data got %h want a0005c", rsp_data);
        end
        next_cycle();
        n_cmp++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_strobe_width got %b want 0000", rsp_valid);
        end
        n_cmp++;
        if (rsp_data !== 24'hA0005C) begin
            n_fail++;
            $display("FAIL single_data_hold got %h want a0005c", rsp_data);
        end
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_g;
        logic [23:0] exp_d;
        do_reset();
        req_addr = 32'h13121110;
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                exp_g = 4'b0001 << (c % 4);
                n_cmp++;
                if (req_ready !== exp_g) begin
                    n_fail++;
                    $display("FAIL rr_grant cyc%0d got %b want %b", c, req_ready, exp_g);
                end
            end
            if (c >= 2) begin
                exp_g = 4'b0001 << ((c - 2) % 4);
                exp_d = 24'hA00010 + 24'((c - 2) % 4);
                n_cmp++;
                if (rsp_valid !== exp_g) begin
                    n_fail++;
                    $display("FAIL rr_rsp_valid cyc%0d got %b want %b", c, rsp_valid, exp_g);
                end
                n_cmp++;
                if (rsp_data !== exp_d) begin
                    n_fail++;
                    $display("FAIL rr_rsp_data cyc%0d got %h want %h", c, rsp_data, exp_d);
                end
            end
            next_cycle();
        end
        req_valid = '0;
    endtask

    task automatic test_rotation();
        // pointer is at lane 3 here
        req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL rot_lane1 got %b want 0010", req_ready);
        end
        next_cycle();
        req_valid = '0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rot_idle_ready got %b want 0000", req_ready);
        end
        next_cycle();
        next_cycle();
        req_valid = 4'b1001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL rot_first got %b want 1000", req_ready);
        end
        next_cycle();
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rot_second got %b want 0001", req_ready);
        end
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_d;
        int bad_ready;
        int bad_rsp;
        bad_ready = 0;
        bad_rsp = 0;
        for (int c = 0; c < 258; c++) begin
            req_valid = (c < 256) ? 4'b0001 : 4'b0000;
            req_addr = {24'h000000, 8'(c)};
            #1;
            if (c < 256) begin
                n_cmp++;
                if (req_ready !== 4'b0001) begin
                    n_fail++;
                    if (bad_ready < 4)
                        $display("FAIL b2b_ready cyc%0d got %b want 0001", c, req_ready);
                    bad_ready++;
                end
            end
            if (c >= 2) begin
                exp_d = 24'hA00000 | 24'(c - 2);
                n_cmp++;
                if (rsp_valid !== 4'b0001 || rsp_data !== exp_d) begin
                    n_fail++;
                    if (bad_rsp < 4)
                        $display("FAIL b2b_rsp cyc%0d got %b/%h want 0001/%h",
                                 c, rsp_valid, rsp_data, exp_d);
                    bad_rsp++;
                end
            end
            next_cycle();
        end
        req_valid = '0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        req_addr = 32'h00332211;
        // cycle 0: lane 1 accepted
        req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL rstmid_acc0 got %b want 0010", req_ready);
        end
        next_cycle();
        // cycle 1: lane 2 granted, then reset raised before the closing edge
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL rstmid_acc1 got %b want 0100", req_ready);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_ready_forced got %b want 0000", req_ready);
        end
        next_cycle();
        rst = 1'b0;
        req_valid = '0;
        for (int c = 2; c < 4; c++) begin
            n_cmp++;
            if (rsp_valid !== 4'b0000) begin
                n_fail++;
                $display("FAIL rstmid_no_rsp cyc%0d got %b want 0000", c, rsp_valid);
            end
            next_cycle();
        end
        req_valid = 4'b1001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstmid_prio got %b want 0001", req_ready);
        end
        next_cycle();
        req_valid = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_rotation();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
